// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: program-memory port, redirect input and IF/ID valid/ready handshake.
// master = fetch unit side, slave = memory/decode/branch-resolution side.
interface if_fetch_unit_if #(
  parameter int unsigned FIFO_DEPTH = 4
) ();
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             imem_req_o;
  logic [31:0]      imem_addr_o;
  logic [31:0]      imem_data_i;
  logic             redirect_i;
  logic [31:0]      redirect_pc_i;
  logic             id_ready_i;
  logic             if_valid_o;
  logic [31:0]      instruction_o;
  logic [31:0]      pc_plus_4_o;
  logic [CNT_W-1:0] fifo_count_o;

  modport master (
    output imem_req_o, imem_addr_o, if_valid_o, instruction_o, pc_plus_4_o, fifo_count_o,
    input  imem_data_i, redirect_i, redirect_pc_i, id_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, if_valid_o, instruction_o, pc_plus_4_o, fifo_count_o,
    output imem_data_i, redirect_i, redirect_pc_i, id_ready_i
  );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: PC, 1-cycle program-memory reads, prefetch FIFO, redirect/stall.
// Define FETCH_BYPASS_EN to present a returning word directly when the FIFO is empty.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  if_fetch_unit_if.master bus
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      pc;
  logic [31:0]      tag;
  logic             inflight;

  logic   issue_c;
  logic   head_vld_c;
  logic   bypass_c;
  logic   out_vld_c;
  logic   push_c;
  logic   pop_c;
  entry_t head_c;

  // A memory slot is reserved at issue time, so the FIFO can never overflow on return.
  always_comb begin
    head_vld_c = (count != '0);
    bypass_c   = 1'b0;
`ifdef FETCH_BYPASS_EN
    bypass_c   = !head_vld_c && inflight && !bus.redirect_i;
`endif
    out_vld_c  = (head_vld_c || bypass_c) && !bus.redirect_i;
    issue_c    = reset && !bus.redirect_i &&
                 ((count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH));
    pop_c      = head_vld_c && out_vld_c && bus.id_ready_i;
    push_c     = inflight && !bus.redirect_i && !(bypass_c && bus.id_ready_i);
    head_c     = '0;
    if (head_vld_c) begin
      head_c = mem[rd_ptr];
    end else if (bypass_c) begin
      head_c = '{instr: bus.imem_data_i, pc4: tag};
    end
  end

  assign bus.imem_req_o    = issue_c;
  assign bus.imem_addr_o   = pc;
  assign bus.if_valid_o    = out_vld_c;
  assign bus.instruction_o = head_c.instr;
  assign bus.pc_plus_4_o   = head_c.pc4;
  assign bus.fifo_count_o  = count;

  // PC, in-flight tracking and FIFO pointers; redirect wins over everything but reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect_i) begin
      pc       <= bus.redirect_pc_i & ~32'h3;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue_c;
      if (issue_c) begin
        pc  <= pc + 32'd4;
        tag <= pc + 32'd4;
      end
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{instr: bus.imem_data_i, pc4: tag};
    end
  end
endmodule
